// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with shadowed, frame-aligned data loads.
// Outputs are registered (1 cycle behind cnt/idx/active); loads are never back-pressured.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DUTY_W      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic                    i_lz_en,
  input  logic [DUTY_W-1:0]       i_duty,
  output logic [6:0]              o_a_to_g,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_dp,
  output logic                    o_pending,
  output logic                    o_frame_done
);

  localparam int CNT_W_RAW = $clog2(REFRESH_DIV);
  localparam int CNT_W     = (CNT_W_RAW > DUTY_W) ? CNT_W_RAW : DUTY_W;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;

  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_sh_lz;
  logic                    r_pending;

  logic [4*NUM_DIGITS-1:0] r_act_value;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic                    r_act_lz;

  logic                    r_frame_done;
  logic [6:0]              r_a_to_g;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;

  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic                    w_run;
  logic [3:0]              w_nib;
  logic                    w_dig_blank;
  logic                    w_dig_lz;
  logic                    w_dig_dp;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_seg;
  logic                    w_dp_n;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
  assign w_commit   = w_boundary && r_pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load on a boundary cycle lands in the shadow after the old shadow commits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_value <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
      r_sh_lz    <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh_value <= i_value;
        r_sh_dp    <= i_dp_mask;
        r_sh_blank <= i_blank_mask;
        r_sh_lz    <= i_lz_en;
        r_pending  <= 1'b1;
      end else if (w_commit) begin
        r_pending  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
      r_act_lz     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      if (w_commit) begin
        r_act_value <= r_sh_value;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
        r_act_lz    <= r_sh_lz;
      end
    end
  end

  // w_run tracks "every nibble from the top down to digit i is zero".
  always_comb begin
    w_run      = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run = w_run & (r_act_value[4*i +: 4] == 4'd0);
      if (i != 0) w_lz_blank[i] = r_act_lz & w_run;
    end
  end

  always_comb begin
    w_nib       = 4'h0;
    w_dig_blank = 1'b0;
    w_dig_lz    = 1'b0;
    w_dig_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_act_value[4*i +: 4];
        w_dig_blank = r_act_blank[i];
        w_dig_lz    = w_lz_blank[i];
        w_dig_dp    = r_act_dp[i];
      end
    end
  end

  always_comb begin
    w_an = '1;
    if (r_cnt[DUTY_W-1:0] <= i_duty) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_idx == IDX_W'(i)) w_an[i] = 1'b0;
      end
    end
    w_seg  = (w_dig_blank || w_dig_lz) ? 7'b1111111 : f_decode(w_nib);
    w_dp_n = w_dig_blank ? 1'b1 : ~w_dig_dp;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_an     <= '1;
      r_a_to_g <= 7'b1111111;
      r_dp     <= 1'b1;
    end else begin
      r_an     <= w_an;
      r_a_to_g <= w_seg;
      r_dp     <= w_dp_n;
    end
  end

  assign o_a_to_g     = r_a_to_g;
  assign o_an         = r_an;
  assign o_dp         = r_dp;
  assign o_pending    = r_pending;
  assign o_frame_done = r_frame_done;

endmodule
